// File: rtl/prbs_lfsr_pkg.sv
// Shared types for the PRBS LFSR generator: step mode and packer FSM states.
package prbs_lfsr_pkg;

  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } gen_state_e;

endpackage

// File: rtl/prbs_lfsr_gen_lfsr_step.sv
// Combinational LFSR step: next state, produced bit and zero detect of the
// next state, for either Fibonacci or Galois form.
import prbs_lfsr_pkg::*;

module lfsr_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] tap_pattern,
  input  lfsr_mode_e       mode,
  output logic [WIDTH-1:0] next_state,
  output logic             bit_out,
  output logic             next_zero
);

  // Next-state function; the produced bit is always the pre-step LSB.
  always_comb begin
    next_state = '0;
    bit_out    = state[0];
    case (mode)
      LFSR_FIB: next_state = {^(state & tap_pattern), state[WIDTH-1:1]};
      LFSR_GAL: next_state = (state >> 1) ^ ({WIDTH{state[0]}} & tap_pattern);
      default:  next_state = '0;
    endcase
    next_zero = (next_state == '0);
  end

endmodule

// File: rtl/prbs_lfsr_gen.sv
// PRBS LFSR generator: WIDTH-bit LFSR with run-time Fibonacci/Galois mode,
// zero-state lockup recovery and packing of the serial stream into OUT_W-bit
// words on a valid/ready output.
// Optional feature: define LFSR_PERIOD_CNT_EN to enable period measurement;
// otherwise period/period_valid are tied to zero.
import prbs_lfsr_pkg::*;

module prbs_lfsr_gen #(
  parameter int unsigned     WIDTH        = 16,
  parameter int unsigned     OUT_W        = 8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load_seed,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] tap_pattern,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             serial_out,
  output logic [WIDTH-1:0] state_out,
  output logic             lockup,
  output logic [WIDTH-1:0] period,
  output logic             period_valid
);

  localparam int unsigned     CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(OUT_W - 1);

  logic [WIDTH-1:0] state_q, state_d;
  gen_state_e       fsm_q, fsm_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] word_q, word_d;
  logic             lockup_q, lockup_d;

  logic [WIDTH-1:0] step_next;
  logic             step_bit;
  logic             step_zero;

  lfsr_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .state      (state_q),
    .tap_pattern(tap_pattern),
    .mode       (lfsr_mode_e'(mode)),
    .next_state (step_next),
    .bit_out    (step_bit),
    .next_zero  (step_zero)
  );

  // Next-state logic: seed load, FSM sequencing, stepping and bit packing.
  always_comb begin
    fsm_d    = fsm_q;
    count_d  = count_q;
    word_d   = word_q;
    state_d  = state_q;
    lockup_d = 1'b0;
    if (load_seed) begin
      fsm_d   = IDLE;
      count_d = '0;
      word_d  = '0;
      if (seed == '0) begin
        state_d  = DEFAULT_SEED;
        lockup_d = 1'b1;
      end else begin
        state_d = seed;
      end
    end else begin
      case (fsm_q)
        IDLE: begin
          if (enable) begin
            fsm_d   = FILL;
            count_d = '0;
          end
        end
        FILL: begin
          if (enable) begin
            word_d[count_q] = step_bit;
            if (step_zero) begin
              state_d  = DEFAULT_SEED;
              lockup_d = 1'b1;
            end else begin
              state_d = step_next;
            end
            if (count_q == LAST) begin
              fsm_d   = HOLD;
              count_d = '0;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            fsm_d   = enable ? FILL : IDLE;
            count_d = '0;
          end
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  // State, FSM, packing and lockup registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DEFAULT_SEED;
      fsm_q    <= IDLE;
      count_q  <= '0;
      word_q   <= '0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fsm_q    <= fsm_d;
      count_q  <= count_d;
      word_q   <= word_d;
      lockup_q <= lockup_d;
    end
  end

  assign out_valid  = (fsm_q == HOLD);
  assign out_data   = word_q;
  assign serial_out = state_q[0];
  assign state_out  = state_q;
  assign lockup     = lockup_q;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] steps_q;
  logic [WIDTH-1:0] period_q;
  logic             period_valid_q;
  logic             step_taken;
  logic             reseed;

  // A step happens only in FILL with enable and no load; a reseed is any
  // write of a fresh reference value (load or zero-state replacement), and
  // state_d already carries that value.
  always_comb begin
    step_taken = (fsm_q == FILL) && enable && !load_seed;
    reseed     = load_seed || (step_taken && step_zero);
  end

  // Period measurement against the last reference state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q          <= DEFAULT_SEED;
      steps_q        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else if (reseed) begin
      ref_q          <= state_d;
      steps_q        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else if (step_taken) begin
      if (!period_valid_q && (steps_q != '1) && (step_next == ref_q)) begin
        period_q       <= steps_q + 1'b1;
        period_valid_q <= 1'b1;
      end
      if (steps_q != '1) begin
        steps_q <= steps_q + 1'b1;
      end
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_prbs_lfsr_gen.sv
// Self-checking bench for prbs_lfsr_gen: an 8-bit and a 4-bit instance, a
// per-cycle behavioural model for each, and hand-computed literal checks.
module tb_prbs_lfsr_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance signals
  logic       en8 = 0, ld8 = 0, mode8 = 0, rdy8 = 0;
  logic [7:0] seed8 = '0, taps8 = '0;
  logic       valid8, ser8, lock8, pv8;
  logic [7:0] data8, st8, per8;

  // 4-bit instance signals
  logic       en4 = 0, ld4 = 0, mode4 = 0, rdy4 = 0;
  logic [3:0] seed4 = '0, taps4 = '0;
  logic       valid4, ser4, lock4, pv4;
  logic [3:0] data4, st4, per4;

  prbs_lfsr_gen #(.WIDTH(8), .OUT_W(8), .DEFAULT_SEED(8'h01)) dut8 (
    .clk(clk), .rst(rst), .enable(en8), .load_seed(ld8), .seed(seed8),
    .tap_pattern(taps8), .mode(mode8), .out_valid(valid8), .out_ready(rdy8),
    .out_data(data8), .serial_out(ser8), .state_out(st8), .lockup(lock8),
    .period(per8), .period_valid(pv8)
  );

  prbs_lfsr_gen #(.WIDTH(4), .OUT_W(4), .DEFAULT_SEED(4'h1)) dut4 (
    .clk(clk), .rst(rst), .enable(en4), .load_seed(ld4), .seed(seed4),
    .tap_pattern(taps4), .mode(mode4), .out_valid(valid4), .out_ready(rdy4),
    .out_data(data4), .serial_out(ser4), .state_out(st4), .lockup(lock4),
    .period(per4), .period_valid(pv4)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = idle, 1 = filling a word, 2 = word offered.
  typedef struct {
    logic [31:0] st;
    int unsigned ph;
    int unsigned cnt;
    logic [31:0] word;
    bit          lock;
    logic [31:0] refv;
    logic [31:0] steps;
    logic [31:0] per;
    bit          pv;
  } mdl_t;

  mdl_t m8, m4;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] taps,
                                            input bit gal, input int unsigned w);
    logic [31:0] mask;
    logic [31:0] x;
    bit fb;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (!gal) begin
      fb = 1'b0;
      for (int unsigned i = 0; i < w; i++) fb = fb ^ (s[i] & taps[i]);
      x = (s >> 1) | (fb ? (32'd1 << (w - 1)) : 32'd0);
    end else begin
      x = (s >> 1) ^ (s[0] ? taps : 32'd0);
    end
    return x & mask;
  endfunction

  function automatic mdl_t model_next(input mdl_t m, input int unsigned w, input int unsigned ow,
                                      input bit r, input bit en, input bit ld,
                                      input logic [31:0] seed, input logic [31:0] taps,
                                      input bit gal, input bit rdy);
    mdl_t n;
    logic [31:0] mask;
    logic [31:0] x;
    n = m;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    n.lock = 1'b0;
    if (r) begin
      n.st = 1; n.ph = 0; n.cnt = 0; n.word = 0;
      n.refv = 1; n.steps = 0; n.per = 0; n.pv = 1'b0;
      return n;
    end
    if (ld) begin
      if ((seed & mask) == 0) begin
        n.st = 1; n.lock = 1'b1;
      end else begin
        n.st = seed & mask;
      end
      n.ph = 0; n.cnt = 0;
      n.refv = n.st; n.steps = 0; n.per = 0; n.pv = 1'b0;
      return n;
    end
    if (m.ph == 0) begin
      if (en) begin n.ph = 1; n.cnt = 0; end
    end else if (m.ph == 1) begin
      if (en) begin
        x = lfsr_next(m.st, taps & mask, gal, w);
        n.word[m.cnt] = m.st[0];
        if (x == 0) begin
          x = 1; n.lock = 1'b1;
          n.refv = 1; n.steps = 0; n.per = 0; n.pv = 1'b0;
        end else begin
          if (!m.pv && m.steps != mask && x == m.refv) begin
            n.per = m.steps + 1; n.pv = 1'b1;
          end
          if (m.steps != mask) n.steps = m.steps + 1;
        end
        n.st = x;
        n.cnt = m.cnt + 1;
        if (n.cnt == ow) begin n.ph = 2; n.cnt = 0; end
      end
    end else begin
      if (rdy) begin n.ph = en ? 1 : 0; n.cnt = 0; end
    end
    return n;
  endfunction

  // Compare process: advance both models on each edge, check outputs after it.
  always @(posedge clk) begin
    m8 = model_next(m8, 8, 8, rst, en8, ld8, {24'd0, seed8}, {24'd0, taps8}, mode8, rdy8);
    m4 = model_next(m4, 4, 4, rst, en4, ld4, {28'd0, seed4}, {28'd0, taps4}, mode4, rdy4);
    #1;
    chk("m8_state", {24'd0, st8}, m8.st);
    chk("m8_serial", {31'd0, ser8}, {31'd0, m8.st[0]});
    chk("m8_valid", {31'd0, valid8}, (m8.ph == 2) ? 32'd1 : 32'd0);
    chk("m8_lockup", {31'd0, lock8}, {31'd0, m8.lock});
    if (m8.ph == 2) chk("m8_data", {24'd0, data8}, m8.word & 32'hFF);
    chk("m4_state", {28'd0, st4}, m4.st);
    chk("m4_serial", {31'd0, ser4}, {31'd0, m4.st[0]});
    chk("m4_valid", {31'd0, valid4}, (m4.ph == 2) ? 32'd1 : 32'd0);
    chk("m4_lockup", {31'd0, lock4}, {31'd0, m4.lock});
    if (m4.ph == 2) chk("m4_data", {28'd0, data4}, m4.word & 32'hF);
`ifdef LFSR_PERIOD_CNT_EN
    chk("m8_period", {24'd0, per8}, m8.per);
    chk("m8_pvalid", {31'd0, pv8}, {31'd0, m8.pv});
    chk("m4_period", {28'd0, per4}, m4.per);
    chk("m4_pvalid", {31'd0, pv4}, {31'd0, m4.pv});
`else
    chk("m8_period_off", {24'd0, per8}, 32'd0);
    chk("m4_pvalid_off", {31'd0, pv4}, 32'd0);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for dut8 out_valid, checking it first appears the given number of
  // edges after the load edge.
  task automatic wait_valid8(input string name, input int exp_lat);
    bit found;
    found = 1'b0;
    for (int i = 1; i <= 30 && !found; i++) begin
      tick();
      if (valid8) begin
        found = 1'b1;
        chk(name, i, exp_lat);
      end
    end
    if (!found) chk({name, "_seen"}, {31'd0, valid8}, 32'd1);
  endtask

  logic [31:0] pat_en  = 32'b1110_1111_0111_1101_1111_1011_1110_1111;
  logic [31:0] pat_rdy = 32'b1011_0011_1100_0111_1010_1101_0011_1111;
  logic [3:0]  gal_seq [4] = '{4'hC, 4'h6, 4'h3, 4'hD};

  initial begin
    // Reset for two cycles
    tick();
    tick();
    chk("rst_state8", {24'd0, st8}, 32'h01);
    chk("rst_valid8", {31'd0, valid8}, 32'd0);
    chk("rst_lock8", {31'd0, lock8}, 32'd0);
    chk("rst_pv8", {31'd0, pv8}, 32'd0);
    chk("rst_data8", {24'd0, data8}, 32'd0);
    chk("rst_state4", {28'd0, st4}, 32'h1);
    rst = 1'b0;

    // Fibonacci, taps 0xB8, seed 0xA5: first word is the seed itself
    ld8 = 1; seed8 = 8'hA5; taps8 = 8'hB8; mode8 = 0; en8 = 1; rdy8 = 0;
    tick();
    ld8 = 0;
    wait_valid8("fib_latency", 9);
    chk("fib_word", {24'd0, data8}, 32'hA5);
    chk("fib_state", {24'd0, st8}, 32'h86);

    // Backpressure: word and state frozen while not accepted
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'd0, valid8}, 32'd1);
      chk("bp_data", {24'd0, data8}, 32'hA5);
      chk("bp_state", {24'd0, st8}, 32'h86);
    end

    // Accept, then abort mid-fill with a new seed
    rdy8 = 1;
    tick();
    tick(); tick(); tick();
    chk("mid_fill_valid", {31'd0, valid8}, 32'd0);
    ld8 = 1; seed8 = 8'h3C;
    tick();
    ld8 = 0;
    chk("abort_valid", {31'd0, valid8}, 32'd0);
    chk("abort_state", {24'd0, st8}, 32'h3C);
    wait_valid8("abort_latency", 9);
    chk("abort_word", {24'd0, data8}, 32'h3C);

    // Mixed enable/ready pattern with a live mode and tap change
    for (int i = 0; i < 48; i++) begin
      en8  = pat_en[i % 32];
      rdy8 = pat_rdy[i % 32];
      if (i == 24) begin mode8 = 1; taps8 = 8'h8E; end
      tick();
    end

    // Galois, 4-bit, taps 0xC, seed 0x1
    ld4 = 1; seed4 = 4'h1; taps4 = 4'hC; mode4 = 1; en4 = 1; rdy4 = 0;
    tick();
    ld4 = 0;
    chk("gal_load", {28'd0, st4}, 32'h1);
    tick();
    chk("gal_idle", {28'd0, st4}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("gal_seq", {28'd0, st4}, {28'd0, gal_seq[k]});
    end
    chk("gal_valid", {31'd0, valid4}, 32'd1);
    chk("gal_word", {28'd0, data4}, 32'h9);

    // Lockup: zero taps drive the next state to zero
    en8 = 1; ld8 = 1; seed8 = 8'h01; taps8 = 8'h00; mode8 = 0; rdy8 = 0;
    tick();
    ld8 = 0;
    chk("lk_load_nolock", {31'd0, lock8}, 32'd0);
    tick();
    tick();
    chk("lk_pulse", {31'd0, lock8}, 32'd1);
    chk("lk_state", {24'd0, st8}, 32'h01);
    en8 = 0;
    tick();
    chk("lk_clear", {31'd0, lock8}, 32'd0);
    ld8 = 1; seed8 = 8'h00;
    tick();
    ld8 = 0;
    chk("lk_zero_seed", {31'd0, lock8}, 32'd1);
    chk("lk_zero_state", {24'd0, st8}, 32'h01);
    tick();
    chk("lk_zero_clear", {31'd0, lock8}, 32'd0);

    // Period: 4-bit Fibonacci, taps 0x3, seed 0x1 has period 15
    ld4 = 1; seed4 = 4'h1; taps4 = 4'h3; mode4 = 0; en4 = 1; rdy4 = 1;
    tick();
    ld4 = 0;
    chk("per_cleared", {31'd0, pv4}, 32'd0);
    repeat (25) tick();
`ifdef LFSR_PERIOD_CNT_EN
    chk("per_value", {28'd0, per4}, 32'd15);
    chk("per_valid", {31'd0, pv4}, 32'd1);
`else
    chk("per_value_off", {28'd0, per4}, 32'd0);
    chk("per_valid_off", {31'd0, pv4}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
